// File: rtl/hpdcache_sram_wbe_banked_if.sv
// rtl/hpdcache_sram_wbe_banked_if.sv - request/response bundle for the banked byte-enable SRAM
//
// Purpose: groups the request handshake, the read response and the status
// flags of hpdcache_sram_wbe_banked into one bundle.
// Ports (signals):
//   req_valid, req_ready         request handshake, accepted when both are 1
//   req_we, req_addr             1 write / 0 read, word address
//   req_wdata, req_wbyteenable   write data and per-byte write enable
//   rsp_valid, rsp_rdata         single-cycle read response and its data
//   init_done                    storage initialised, block operational
//   parity_err                   byte parity mismatch flagged with rsp_valid
// Modports: master drives requests, slave is the storage side.
interface hpdcache_sram_wbe_banked_if #(
   parameter int unsigned ADDR_SIZE = 6,
   parameter int unsigned DATA_SIZE = 64
) ();
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDR_SIZE-1:0]     req_addr;
   logic [DATA_SIZE-1:0]     req_wdata;
   logic [DATA_SIZE/8-1:0]   req_wbyteenable;
   logic                     rsp_valid;
   logic [DATA_SIZE-1:0]     rsp_rdata;
   logic                     init_done;
   logic                     parity_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wbyteenable,
      input  req_ready, rsp_valid, rsp_rdata, init_done, parity_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wbyteenable,
      output req_ready, rsp_valid, rsp_rdata, init_done, parity_err
   );
endinterface

// File: rtl/hpdcache_sram_wbe_banked.sv
// rtl/hpdcache_sram_wbe_banked.sv - banked 1RW byte-enable SRAM wrapper with init sweep
//
// Purpose: word storage split into NBANKS address-interleaved banks
// (bank = addr mod NBANKS, row = addr / NBANKS). Accepts one access per
// cycle through a valid/ready port, returns read data with a one-cycle
// response pulse (two cycles with OUT_REG=1), and optionally zero-fills
// all storage after reset before accepting requests.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    hpdcache_sram_wbe_banked_if.slave (request, response, status)
// Optional feature macro: HPDCACHE_SRAM_PARITY_EN
//   defined   - one even-parity bit per byte stored per bank, checked on read
//   undefined - no parity storage, parity_err stays 0
module hpdcache_sram_wbe_banked #(
   parameter int unsigned ADDR_SIZE     = 6,
   parameter int unsigned DATA_SIZE     = 64,
   parameter int unsigned DEPTH         = 2**ADDR_SIZE,
   parameter int unsigned NBANKS        = 2,
   parameter bit          OUT_REG       = 1'b0,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   hpdcache_sram_wbe_banked_if.slave  bus
);

   localparam int unsigned NBYTES  = DATA_SIZE / 8;
   localparam int unsigned ROWS    = DEPTH / NBANKS;
   localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BANK_SH = $clog2(NBANKS);
   localparam int unsigned BANK_W  = (NBANKS > 1) ? BANK_SH : 1;

   if (DATA_SIZE % 8 != 0) begin : g_chk_data
      $error("DATA_SIZE must be a multiple of 8");
   end
   if (NBANKS == 0 || (NBANKS & (NBANKS - 1)) != 0) begin : g_chk_banks
      $error("NBANKS must be a power of two");
   end
   if (DEPTH % NBANKS != 0) begin : g_chk_depth
      $error("DEPTH must be a multiple of NBANKS");
   end

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   init_row_q, init_row_d;
   logic               in_init;
   logic               run;

   // ---------------- address split ----------------
   logic [BANK_W-1:0]  bank_sel;
   logic [ROW_W-1:0]   row_addr;

   if (NBANKS > 1) begin : g_bsel
      assign bank_sel = bus.req_addr[BANK_W-1:0];
   end else begin : g_bsel_one
      assign bank_sel = '0;
   end
   assign row_addr = bus.req_addr[BANK_SH +: ROW_W];

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         init_row_q <= '0;
      end else begin
         state_q    <= state_d;
         init_row_q <= init_row_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_row_d = init_row_q;
      in_init    = 1'b0;
      run        = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            in_init = 1'b1;
            if (init_row_q == ROW_W'(ROWS - 1)) begin
               state_d = ST_RUN;
            end else begin
               init_row_d = init_row_q + ROW_W'(1);
            end
         end
         ST_RUN: begin
            run = 1'b1;
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // ---------------- request decode ----------------
   logic                acc;
   logic                rd_acc;
   logic [NBANKS-1:0]   bank_cs;
   logic [ROW_W-1:0]    wr_row;
   logic [DATA_SIZE-1:0] wr_data;
   logic [NBYTES-1:0]   wr_be [NBANKS];

   assign acc    = bus.req_valid & run;
   assign rd_acc = acc & ~bus.req_we;

   // The init sweep writes zeros through the normal write path, all banks
   // and all bytes at once, so storage needs only one write port per bank.
   always_comb begin
      wr_row  = in_init ? init_row_q : row_addr;
      wr_data = in_init ? '0 : bus.req_wdata;
      for (int b = 0; b < int'(NBANKS); b++) begin
         bank_cs[b] = acc && (bank_sel == BANK_W'(b));
         if (in_init) begin
            wr_be[b] = '1;
         end else if (bank_cs[b] && bus.req_we) begin
            wr_be[b] = bus.req_wbyteenable;
         end else begin
            wr_be[b] = '0;
         end
      end
   end

   // ---------------- storage ----------------
   logic [DATA_SIZE-1:0] mem [NBANKS][ROWS];
`ifdef HPDCACHE_SRAM_PARITY_EN
   logic [NBYTES-1:0]    par_mem [NBANKS][ROWS];
`endif

   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(NBANKS); b++) begin
         for (int i = 0; i < int'(NBYTES); i++) begin
            if (wr_be[b][i]) begin
               mem[b][wr_row][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef HPDCACHE_SRAM_PARITY_EN
               par_mem[b][wr_row][i]    <= ^wr_data[8*i +: 8];
`endif
            end
         end
      end
   end

   // ---------------- read path ----------------
   logic [DATA_SIZE-1:0] rd_word;
   logic                 rd_perr;

   assign rd_word = mem[bank_sel][row_addr];

`ifdef HPDCACHE_SRAM_PARITY_EN
   logic [NBYTES-1:0] rd_par_calc;
   always_comb begin
      for (int i = 0; i < int'(NBYTES); i++) begin
         rd_par_calc[i] = ^rd_word[8*i +: 8];
      end
   end
   assign rd_perr = |(rd_par_calc ^ par_mem[bank_sel][row_addr]);
`else
   assign rd_perr = 1'b0;
`endif

   // Data registers only load on a response so rsp_rdata holds between pulses.
   logic                 s1_valid;
   logic [DATA_SIZE-1:0] s1_data;
   logic                 s1_perr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_perr  <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_data <= rd_word;
            s1_perr <= rd_perr;
         end
      end
   end

   logic                 out_valid;
   logic [DATA_SIZE-1:0] out_data;
   logic                 out_perr;

   if (OUT_REG) begin : g_oreg
      logic                 s2_valid;
      logic [DATA_SIZE-1:0] s2_data;
      logic                 s2_perr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_perr  <= 1'b0;
         end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_data;
               s2_perr <= s1_perr;
            end
         end
      end

      assign out_valid = s2_valid;
      assign out_data  = s2_data;
      assign out_perr  = s2_perr;
   end else begin : g_no_oreg
      assign out_valid = s1_valid;
      assign out_data  = s1_data;
      assign out_perr  = s1_perr;
   end

   assign bus.req_ready  = run;
   assign bus.init_done  = run;
   assign bus.rsp_valid  = out_valid;
   assign bus.rsp_rdata  = out_data;
   assign bus.parity_err = out_valid & out_perr;

endmodule

// File: tb/tb_hpdcache_sram_wbe_banked.sv
// tb/tb_hpdcache_sram_wbe_banked.sv - bench for hpdcache_sram_wbe_banked (OUT_REG 0 and 1)
module tb_hpdcache_sram_wbe_banked;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [5:0]  req_addr  = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_be    = '0;

   hpdcache_sram_wbe_banked_if #(.ADDR_SIZE(6), .DATA_SIZE(64)) bus0 ();
   hpdcache_sram_wbe_banked_if #(.ADDR_SIZE(6), .DATA_SIZE(64)) bus1 ();

   assign bus0.req_valid       = req_valid;
   assign bus0.req_we          = req_we;
   assign bus0.req_addr        = req_addr;
   assign bus0.req_wdata       = req_wdata;
   assign bus0.req_wbyteenable = req_be;
   assign bus1.req_valid       = req_valid;
   assign bus1.req_we          = req_we;
   assign bus1.req_addr        = req_addr;
   assign bus1.req_wdata       = req_wdata;
   assign bus1.req_wbyteenable = req_be;

   hpdcache_sram_wbe_banked #(.ADDR_SIZE(6), .DATA_SIZE(64), .DEPTH(64), .NBANKS(2),
                              .OUT_REG(1'b0), .INIT_ON_RESET(1'b1))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   hpdcache_sram_wbe_banked #(.ADDR_SIZE(6), .DATA_SIZE(64), .DEPTH(64), .NBANKS(2),
                              .OUT_REG(1'b1), .INIT_ON_RESET(1'b1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic        v;
      logic        we;
      logic [5:0]  addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [63:0] exp;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   int total = 0;
   int bad   = 0;

   // expected responses: p0 = request issued one cycle ago, p1 = two cycles ago
   logic        p0v, p1v, p0pe, p1pe;
   logic [63:0] p0d, p1d, last0, last1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_pipe();
      p0v = 1'b0; p1v = 1'b0; p0pe = 1'b0; p1pe = 1'b0;
      p0d = '0;   p1d = '0;   last0 = '0;  last1 = '0;
   endtask

   task automatic check_rsp();
      chk("rsp_valid0", 64'(bus0.rsp_valid), 64'(p0v));
      if (p0v) begin
         chk("rdata0", bus0.rsp_rdata, p0d);
         last0 = p0d;
      end else begin
         chk("rdata_hold0", bus0.rsp_rdata, last0);
      end
      chk("parity_err0", 64'(bus0.parity_err), 64'(p0v & p0pe));
      chk("rsp_valid1", 64'(bus1.rsp_valid), 64'(p1v));
      if (p1v) begin
         chk("rdata1", bus1.rsp_rdata, p1d);
         last1 = p1d;
      end else begin
         chk("rdata_hold1", bus1.rsp_rdata, last1);
      end
      chk("parity_err1", 64'(bus1.parity_err), 64'(p1v & p1pe));
   endtask

   task automatic do_cycle(input logic v, input logic we, input logic [5:0] a,
                           input logic [63:0] d, input logic [7:0] be,
                           input logic [63:0] exp, input logic pe);
      @(negedge clk);
      check_rsp();
      p1v = p0v; p1d = p0d; p1pe = p0pe;
      p0v = v & ~we; p0d = exp; p0pe = pe;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      #1;
      chk("req_ready0", 64'(bus0.req_ready), 64'd1);
      chk("req_ready1", 64'(bus1.req_ready), 64'd1);
      chk("bank_cs", 64'(dut0.bank_cs), v ? (a[0] ? 64'd2 : 64'd1) : 64'd0);
   endtask

   // Called right after reset release on a falling edge, with an all-ones
   // write to address 0 held on the port; the write must be ignored.
   task automatic init_count();
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         chk("init_ready0", 64'(bus0.req_ready), 64'(k >= 32));
         chk("init_ready1", 64'(bus1.req_ready), 64'(k >= 32));
         chk("init_done0",  64'(bus0.init_done), 64'(k >= 32));
         chk("init_done1",  64'(bus1.init_done), 64'(k >= 32));
         chk("init_rsp0",   64'(bus0.rsp_valid), 64'd0);
         chk("init_rsp1",   64'(bus1.rsp_valid), 64'd0);
         if (k >= 32) req_valid = 1'b0;
      end
   endtask

   task automatic hold_init_write();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd0;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_be = 8'hFF;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 6'd5,  64'h1122334455667788, 8'h0F, 64'h0};
      vecs[1]  = '{1'b1, 1'b0, 6'd5,  64'h0,                8'h00, 64'h0000000055667788};
      vecs[2]  = '{1'b1, 1'b1, 6'd4,  64'hA0A1A2A3A4A5A6A7, 8'hFF, 64'h0};
      vecs[3]  = '{1'b1, 1'b1, 6'd5,  64'hB0B1B2B3B4B5B6B7, 8'hFF, 64'h0};
      vecs[4]  = '{1'b1, 1'b0, 6'd4,  64'h0,                8'h00, 64'hA0A1A2A3A4A5A6A7};
      vecs[5]  = '{1'b1, 1'b0, 6'd5,  64'h0,                8'h00, 64'hB0B1B2B3B4B5B6B7};
      vecs[6]  = '{1'b1, 1'b0, 6'd4,  64'h0,                8'h00, 64'hA0A1A2A3A4A5A6A7};
      vecs[7]  = '{1'b1, 1'b1, 6'd9,  64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0};
      vecs[8]  = '{1'b1, 1'b0, 6'd9,  64'h0,                8'h00, 64'hDEADBEEFCAFEF00D};
      vecs[9]  = '{1'b1, 1'b1, 6'd9,  64'h0123456789ABCDEF, 8'h00, 64'h0};
      vecs[10] = '{1'b1, 1'b0, 6'd9,  64'h0,                8'h00, 64'hDEADBEEFCAFEF00D};
      vecs[11] = '{1'b1, 1'b1, 6'd9,  64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0};
      vecs[12] = '{1'b1, 1'b0, 6'd9,  64'h0,                8'h00, 64'hFFADBEEFCAFEF0FF};
      vecs[13] = '{1'b1, 1'b0, 6'd63, 64'h0,                8'h00, 64'h0};
      vecs[14] = '{1'b0, 1'b0, 6'd0,  64'h0,                8'h00, 64'h0};
      vecs[15] = '{1'b1, 1'b0, 6'd0,  64'h0,                8'h00, 64'h0};

      clear_pipe();
      hold_init_write();
      repeat (3) @(negedge clk);
      chk("rst_ready0",  64'(bus0.req_ready),  64'd0);
      chk("rst_ready1",  64'(bus1.req_ready),  64'd0);
      chk("rst_done0",   64'(bus0.init_done),  64'd0);
      chk("rst_done1",   64'(bus1.init_done),  64'd0);
      chk("rst_valid0",  64'(bus0.rsp_valid),  64'd0);
      chk("rst_valid1",  64'(bus1.rsp_valid),  64'd0);
      chk("rst_rdata0",  bus0.rsp_rdata,       64'd0);
      chk("rst_rdata1",  bus1.rsp_rdata,       64'd0);
      chk("rst_perr0",   64'(bus0.parity_err), 64'd0);
      chk("rst_perr1",   64'(bus1.parity_err), 64'd0);
      rst_n = 1'b1;
      init_count();

      // whole memory must read back zero
      for (int a = 0; a < 64; a++) begin
         do_cycle(1'b1, 1'b0, 6'(a), 64'h0, 8'h00, 64'h0, 1'b0);
      end

      for (int i = 0; i < NVEC; i++) begin
         do_cycle(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].be, vecs[i].exp, 1'b0);
      end

`ifdef HPDCACHE_SRAM_PARITY_EN
      do_cycle(1'b1, 1'b1, 6'd3, 64'hFF, 8'h01, 64'h0, 1'b0);
      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      dut0.par_mem[1][1][0] = ~dut0.par_mem[1][1][0];
      dut1.par_mem[1][1][0] = ~dut1.par_mem[1][1][0];
      do_cycle(1'b1, 1'b0, 6'd3, 64'h0, 8'h00, 64'hFF, 1'b1);
      do_cycle(1'b1, 1'b0, 6'd2, 64'h0, 8'h00, 64'h0, 1'b0);
`endif

      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);

      // reset in the middle of the init sweep
      @(negedge clk);
      rst_n = 1'b0;
      hold_init_write();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midinit_ready0", 64'(bus0.req_ready), 64'd0);
      chk("midinit_ready1", 64'(bus1.req_ready), 64'd0);
      chk("midinit_done0",  64'(bus0.init_done), 64'd0);
      rst_n = 1'b1;
      init_count();
      clear_pipe();
      do_cycle(1'b1, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      do_cycle(1'b1, 1'b0, 6'd5, 64'h0, 8'h00, 64'h0, 1'b0);

      // reset one cycle after a read is accepted
      do_cycle(1'b1, 1'b1, 6'd4, 64'h5A5A_0F0F_1234_8765, 8'hFF, 64'h0, 1'b0);
      do_cycle(1'b1, 1'b0, 6'd4, 64'h0, 8'h00, 64'h5A5A_0F0F_1234_8765, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req_valid = 1'b0;
      clear_pipe();
      repeat (3) begin
         @(negedge clk);
         check_rsp();
      end
      hold_init_write();
      rst_n = 1'b1;
      init_count();
      clear_pipe();
      do_cycle(1'b1, 1'b0, 6'd4, 64'h0, 8'h00, 64'h0, 1'b0);
      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      do_cycle(1'b0, 1'b0, 6'd0, 64'h0, 8'h00, 64'h0, 1'b0);
      @(negedge clk);
      check_rsp();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hpdcache_sram_wbe_banked.md
Name: hpdcache_sram_wbe_banked

Overview:
Parametrised successor to the HPDcache 1RW byte-enable SRAM wrapper.
- Splits storage into NBANKS address-interleaved banks; only the addressed bank is enabled per access.
- Adds a valid/ready request port, a read-response valid, an optional output pipeline register, and a zero-initialisation sweep after reset.
- Sits between HPDcache data/directory controllers and physical storage.

Parameters:
ADDR_SIZE, 6, word address width
DATA_SIZE, 64, word width in bits; multiple of 8
DEPTH, 2**ADDR_SIZE, total words; multiple of NBANKS
NBANKS, 2, bank count; power of two, >=1; bank = addr mod NBANKS, row = addr / NBANKS
OUT_REG, 0, 1 adds a registered stage on read data
INIT_ON_RESET, 1, 1 zero-fills all storage after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  access request
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1 write, 0 read
req_addr  in  ADDR_SIZE  word address
req_wdata  in  DATA_SIZE  write data
req_wbyteenable  in  DATA_SIZE/8  per-byte write enable
rsp_valid  out  1  read data valid, single-cycle pulse
rsp_rdata  out  DATA_SIZE  read data
init_done  out  1  storage initialised, block operational
parity_err  out  1  byte parity mismatch on rsp (see Optional Feature)

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: req_ready=0 if INIT_ON_RESET else 1; rsp_valid=0; rsp_rdata=0; init_done=INIT_ON_RESET?0:1; parity_err=0. Pipeline valids and init counter are cleared.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_ON_RESET, else RUN.
  - INIT: row counter runs 0..DEPTH/NBANKS-1. Each cycle, all banks write zero (all byte enables) at that row.
  - After the last row, the next cycle goes to RUN: init_done=1, req_ready=1.
  - Sweep length is exactly DEPTH/NBANKS cycles. req_ready=0 throughout INIT. Requests during INIT are ignored, not queued.
- RUN: req_ready=1 permanently; one access per cycle; no response backpressure.
- Write accepted at cycle t: bytes with req_wbyteenable[i]=1 update at the clk edge ending t. Other bytes keep their value. All-zero enable means no change. No response.
- Read accepted at cycle t:
  - rsp_valid=1 in cycle t+1 (OUT_REG=0) or t+2 (OUT_REG=1), for exactly one cycle.
  - rsp_rdata holds the word at the addressed location.
- Read in cycle t+1 of a location written in cycle t returns the new data. No bypass is needed because writes commit before the next access.
- rsp_rdata holds its last value while rsp_valid=0.
- Bank enable: only bank req_addr mod NBANKS sees chip-select on an accepted request. All banks are idle when no request is accepted.
- Back-to-back reads, any mix of banks, produce consecutive rsp_valid pulses in order.
- Async reset mid-INIT or mid-read: pipeline discarded, no rsp_valid for in-flight reads, FSM restarts per reset rule.
- Storage contents are undefined after reset when INIT_ON_RESET=0.
- Elaboration checks: DATA_SIZE%8==0, NBANKS power of two, DEPTH%NBANKS==0.

Optional Feature:
HPDCACHE_SRAM_PARITY_EN
- Defined:
  - Each bank stores one even-parity bit per byte alongside data.
  - Writes compute parity for the enabled bytes only.
  - Reads recompute parity. parity_err=1 coincident with rsp_valid if any byte mismatches, else 0.
  - INIT writes parity 0 with data 0.
- Not defined: no parity storage; parity_err tied 0.

Test Plan:
- INIT_ON_RESET=1, DEPTH=64, NBANKS=2: release reset, hold req_valid=1 -> req_ready/init_done rise exactly 32 cycles after reset release, and all 64 words read back 0.
- Write addr 5, wdata 0x1122334455667788, wbyteenable 0x0F over zeroed memory; read 5 -> rsp_rdata 0x0000000055667788, rsp_valid 1 cycle after read accept (OUT_REG=0), 2 cycles with OUT_REG=1.
- Write addr 4 then addr 5 with distinct data, then back-to-back reads 4,5,4 -> three consecutive rsp_valid pulses with matching data. Only bank 0 is enabled for addr 4 and only bank 1 for addr 5.
- Write addr 9 in cycle t, read addr 9 in cycle t+1 -> new data returned; write with wbyteenable=0 then read -> data unchanged.
- Assert rst_n=0 midway through INIT and one cycle after a read accept -> rsp_valid stays 0, INIT restarts from row 0 and lasts a full 32 cycles.
- HPDCACHE_SRAM_PARITY_EN: write addr 3 with 0xFF in byte 0, force the stored byte-0 parity bit to flip, read addr 3 -> parity_err=1 with rsp_valid. Reading an unforced address -> parity_err=0.
